// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO and runs MULT/MULTU/DIV/DIVU as
// fixed-latency operations whose result is committed when the busy counter expires.
module ex_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MduOp,
  input  logic        Valid,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  localparam int DATA_W  = 32;
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Signed divide returning {remainder, quotient}; the one overflowing case
  // (most-negative / -1) is pinned to quotient=most-negative, remainder=0.
  function automatic logic [2*DATA_W-1:0] sdiv(input logic signed [DATA_W-1:0] n,
                                               input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    if (d == '0) return '0;
    if (n == 32'sh8000_0000 && d == -32'sd1) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] udiv(input logic [DATA_W-1:0] n,
                                               input logic [DATA_W-1:0] d);
    if (d == '0) return '0;
    return {n % d, n / d};
  endfunction

  logic signed [DATA_W-1:0]   a_s, b_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic                       accept;

  logic [CNT_W-1:0]    cnt_p1;
  logic [2*DATA_W-1:0] res_p1;
  logic                wr_p1;
  logic [DATA_W-1:0]   hi, lo;

  assign a_s    = $signed(A);
  assign b_s    = $signed(B);
  assign prod_s = 64'(a_s) * 64'(b_s);
  assign prod_u = 64'(A) * 64'(B);

  assign Busy   = (cnt_p1 != '0);
  assign accept = Valid && !Busy && (MduOp >= OP_MULT) && (MduOp <= OP_MTLO);

  // p0 -> p1: operands sampled on accept, result parked until the counter expires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p1 <= '0;
      res_p1 <= '0;
      wr_p1  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      case (MduOp)
        OP_MULT: begin
          res_p1 <= prod_s;
          wr_p1  <= 1'b1;
          cnt_p1 <= CNT_W'(MUL_CYCLES);
        end
        OP_MULTU: begin
          res_p1 <= prod_u;
          wr_p1  <= 1'b1;
          cnt_p1 <= CNT_W'(MUL_CYCLES);
        end
        OP_DIV: begin
          res_p1 <= sdiv(a_s, b_s);
          wr_p1  <= (B != '0);
          cnt_p1 <= CNT_W'(DIV_CYCLES);
        end
        OP_DIVU: begin
          res_p1 <= udiv(A, B);
          wr_p1  <= (B != '0);
          cnt_p1 <= CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        default: ;
      endcase
    end else if (Busy) begin
      cnt_p1 <= cnt_p1 - CNT_W'(1);
      // Divide-by-zero still occupies the unit but leaves HI/LO untouched.
      if (cnt_p1 == CNT_W'(1) && wr_p1) begin
        hi <= res_p1[2*DATA_W-1:DATA_W];
        lo <= res_p1[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    Out = '0;
    if (Valid && MduOp == OP_MFHI) Out = hi;
    else if (Valid && MduOp == OP_MFLO) Out = lo;
  end

  assign HiOut = hi;
  assign LoOut = lo;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: expected {HI,LO} results are queued at issue and
// checked when Busy falls.
module tb_ex_mdu;

  logic        clk;
  logic        reset_n;
  logic [31:0] A, B;
  logic [3:0]  MduOp;
  logic        Valid;
  logic        Busy;
  logic [31:0] Out, HiOut, LoOut;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  ex_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .MduOp(MduOp), .Valid(Valid),
    .Busy(Busy), .Out(Out), .HiOut(HiOut), .LoOut(LoOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Valid = v;
    MduOp = op;
    A     = a;
    B     = b;
  endtask

  // Issue a multi-cycle op, optionally present MTHI 0x5555 while busy, then
  // check busy length and the committed result against the scoreboard.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [63:0] exp,
                        input bit interfere);
    int cnt;
    logic [63:0] want;
    sb.push_back(exp);
    drive(1'b1, op, a, b);
    tick();
    if (interfere) drive(1'b1, 4'd7, 32'h0000_5555, 32'h0);
    else drive(1'b0, 4'd0, 32'h0, 32'h0);
    cnt = 0;
    while (Busy && cnt < 200) begin
      cnt++;
      tick();
    end
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    check({tag, "_busy_len"}, 64'(cnt), 64'(n));
    want = sb.pop_front();
    check({tag, "_hilo"}, {HiOut, LoOut}, want);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 4'd5, 32'h0, 32'h0);
    #2;
    check("rst_busy_held", 64'(Busy), 64'd0);
    check("rst_out_held", 64'(Out), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // 1: reads after reset
    drive(1'b1, 4'd5, 32'h0, 32'h0);
    #1 check("mfhi_rst", 64'(Out), 64'd0);
    drive(1'b1, 4'd6, 32'h0, 32'h0);
    #1 check("mflo_rst", 64'(Out), 64'd0);
    check("busy_rst", 64'(Busy), 64'd0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);

    // 2: multiplies
    run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 64'h0000_0002_FFFF_FFFA, 1'b0);

    // 3: divides, including divide by zero and overflow
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("divu", 4'd4, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003, 1'b0);
    drive(1'b1, 4'd7, 32'h0000_1234, 32'h0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    check("mthi_hi", 64'(HiOut), 64'h1234);
    run_op("div_zero", 4'd3, 32'd99, 32'd0, 10, 64'h0000_1234_0000_0003, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0);

    // 4: MTLO then MFLO; MTHI while busy is ignored
    drive(1'b1, 4'd8, 32'hDEAD_BEEF, 32'h0);
    tick();
    check("mtlo_busy", 64'(Busy), 64'd0);
    drive(1'b1, 4'd6, 32'h0, 32'h0);
    #1 check("mflo_after_mtlo", 64'(Out), 64'hDEAD_BEEF);
    drive(1'b0, 4'd6, 32'h0, 32'h0);
    #1 check("mflo_invalid_out", 64'(Out), 64'd0);
    tick();
    run_op("mult_mthi_busy", 4'd1, 32'h0001_0000, 32'h0001_0000, 5, 64'h0000_0001_0000_0000, 1'b1);

    // 5: reset mid-divide, then recovery
    drive(1'b1, 4'd3, 32'd1000, 32'd7);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_hilo", {HiOut, LoOut}, 64'd0);
    tick();
    reset_n = 1'b1;
    run_op("mult_after_rst", 4'd1, 32'd6, 32'd7, 5, 64'd42, 1'b0);

    // 6: back-to-back read of the new LO, then a flushed MULT
    run_op("mult_big", 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 64'h3FFF_FFFF_0000_0001, 1'b0);
    drive(1'b1, 4'd6, 32'h0, 32'h0);
    #1 check("mflo_first_free", 64'(Out), 64'h0000_0001);
    tick();
    drive(1'b0, 4'd1, 32'd5, 32'd5);
    tick();
    check("flush_busy", 64'(Busy), 64'd0);
    tick();
    check("flush_hilo", {HiOut, LoOut}, 64'h3FFF_FFFF_0000_0001);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
